// File: rtl/dma_pkg.sv
// Shared types, limits and the rotating-priority search used by the DMA request arbiter.
package dma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HREQ  = 2'd1,
        ARB_GRANT = 2'd2,
        ARB_REL   = 2'd3
    } dma_arb_state_e;

    localparam int DMA_MAX_CH = 16;
    localparam int DMA_IDX_W  = 4;

    // Search upward from ptr with 4-bit wrap. Bits above NUM_CH are zero, so the
    // wrap at 16 gives the same winner as a wrap at NUM_CH.
    function automatic logic [DMA_IDX_W-1:0] rot_first(
        input logic [DMA_MAX_CH-1:0] req,
        input logic [DMA_IDX_W-1:0]  ptr
    );
        logic [DMA_IDX_W-1:0] win;
        logic [DMA_IDX_W-1:0] pos;
        logic                 found;
        win   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < DMA_MAX_CH; i++) begin
            pos = ptr + DMA_IDX_W'(i);
            if (!found && req[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dma_prio_enc.sv
// Combinational rotating priority encoder: highest priority at index ptr, wrapping upward.
module dma_prio_enc
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [DMA_MAX_CH-1:0] req_ext_s;
    logic [DMA_IDX_W-1:0]  ptr_ext_s;
    logic [DMA_IDX_W-1:0]  win_s;
    logic                  unused_win_s;

    // Widen to the package limits and pick the first requester at or after ptr
    always_comb begin
        req_ext_s               = '0;
        req_ext_s[NUM_CH-1:0]   = req;
        ptr_ext_s               = '0;
        ptr_ext_s[IDX_W-1:0]    = ptr;
        win_s                   = rot_first(req_ext_s, ptr_ext_s);
        idx                     = win_s[IDX_W-1:0];
        any                     = |req;
    end

    assign unused_win_s = ^win_s;

endmodule

// File: rtl/dma_prio_arbiter.sv
// DMA channel request arbiter and HRQ/HLDA bus-hold sequencer.
// Optional software requests are enabled by defining DMA_SW_REQ_EN.
module dma_prio_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int DREQ_ACTIVE_HIGH = 1,
    parameter int DACK_ACTIVE_HIGH = 0,
    parameter int SYNC_STAGES      = 2,
    localparam int IDX_W           = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    input  logic [NUM_CH-1:0] cfg_mask,
    input  logic              cfg_rot_prio,
`ifdef DMA_SW_REQ_EN
    input  logic              sw_req_set,
    input  logic              sw_req_clr,
    input  logic [IDX_W-1:0]  sw_req_ch,
`endif
    output logic              svc_valid,
    output logic [IDX_W-1:0]  svc_ch,
    input  logic              svc_done,
    input  logic              svc_tc
);

    localparam logic [NUM_CH-1:0] DACK_IDLE = (DACK_ACTIVE_HIGH != 0) ? '0 : '1;

    logic [NUM_CH-1:0] dreq_norm_s;
    logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
    logic [NUM_CH-1:0] sw_req_s;
    logic [NUM_CH-1:0] elig_s;
    logic [IDX_W-1:0]  enc_ptr_s;
    logic [IDX_W-1:0]  win_s;
    logic              any_s;
    logic [NUM_CH-1:0] win_onehot_s;

    dma_arb_state_e    state_r, state_nx_s;
    logic              hrq_r, hrq_nx_s;
    logic [NUM_CH-1:0] dack_r, dack_nx_s;
    logic              svc_valid_r, svc_valid_nx_s;
    logic [IDX_W-1:0]  svc_ch_r, svc_ch_nx_s;
    logic [IDX_W-1:0]  ptr_r, ptr_nx_s;

    assign dreq_norm_s = (DREQ_ACTIVE_HIGH != 0) ? DREQ : ~DREQ;

    // DREQ synchroniser chain, operating on active-high requests
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= dreq_norm_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef DMA_SW_REQ_EN
    logic [NUM_CH-1:0] sw_req_r, sw_req_nx_s;

    // Software request update: set, then clear overrides, then TC auto-clear
    always_comb begin
        sw_req_nx_s = sw_req_r;
        if (sw_req_set) begin
            sw_req_nx_s[sw_req_ch] = 1'b1;
        end else begin
            sw_req_nx_s = sw_req_nx_s;
        end
        if (sw_req_clr) begin
            sw_req_nx_s[sw_req_ch] = 1'b0;
        end else begin
            sw_req_nx_s = sw_req_nx_s;
        end
        if ((state_r == ARB_GRANT) && svc_done && svc_tc) begin
            sw_req_nx_s[svc_ch_r] = 1'b0;
        end else begin
            sw_req_nx_s = sw_req_nx_s;
        end
    end

    // Software request register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_req_r <= '0;
        end else begin
            sw_req_r <= sw_req_nx_s;
        end
    end

    assign sw_req_s = sw_req_r;
`else
    logic unused_tc_s;
    assign sw_req_s    = '0;
    assign unused_tc_s = svc_tc;
`endif

    assign elig_s    = (sync_r[SYNC_STAGES-1] | sw_req_s) & ~cfg_mask;
    assign enc_ptr_s = cfg_rot_prio ? ptr_r : '0;

    dma_prio_enc #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_prio_enc (
        .req (elig_s),
        .ptr (enc_ptr_s),
        .idx (win_s),
        .any (any_s)
    );

    // Next state and next registered outputs of the bus-hold sequencer
    always_comb begin
        state_nx_s     = state_r;
        hrq_nx_s       = hrq_r;
        dack_nx_s      = dack_r;
        svc_valid_nx_s = svc_valid_r;
        svc_ch_nx_s    = svc_ch_r;
        ptr_nx_s       = ptr_r;
        win_onehot_s   = '0;
        win_onehot_s[win_s] = 1'b1;
        case (state_r)
            ARB_IDLE: begin
                if (any_s && !HLDA) begin
                    state_nx_s = ARB_HREQ;
                    hrq_nx_s   = 1'b1;
                end else begin
                    state_nx_s = ARB_IDLE;
                end
            end
            ARB_HREQ: begin
                if (HLDA && any_s) begin
                    state_nx_s     = ARB_GRANT;
                    svc_ch_nx_s    = win_s;
                    dack_nx_s      = DACK_IDLE ^ win_onehot_s;
                    svc_valid_nx_s = 1'b1;
                end else if (HLDA) begin
                    // Request vanished before the bus was granted: release without DACK
                    state_nx_s = ARB_REL;
                    hrq_nx_s   = 1'b0;
                end else begin
                    state_nx_s = ARB_HREQ;
                end
            end
            ARB_GRANT: begin
                if (svc_done || !HLDA) begin
                    state_nx_s     = ARB_REL;
                    hrq_nx_s       = 1'b0;
                    dack_nx_s      = DACK_IDLE;
                    svc_valid_nx_s = 1'b0;
                    ptr_nx_s       = (svc_ch_r == IDX_W'(NUM_CH - 1)) ? '0 : svc_ch_r + IDX_W'(1);
                end else begin
                    state_nx_s = ARB_GRANT;
                end
            end
            ARB_REL: begin
                if (!HLDA) begin
                    state_nx_s = ARB_IDLE;
                end else begin
                    state_nx_s = ARB_REL;
                end
            end
            default: begin
                state_nx_s     = ARB_IDLE;
                hrq_nx_s       = 1'b0;
                dack_nx_s      = DACK_IDLE;
                svc_valid_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ARB_IDLE;
            hrq_r       <= 1'b0;
            dack_r      <= DACK_IDLE;
            svc_valid_r <= 1'b0;
            svc_ch_r    <= '0;
            ptr_r       <= '0;
        end else begin
            state_r     <= state_nx_s;
            hrq_r       <= hrq_nx_s;
            dack_r      <= dack_nx_s;
            svc_valid_r <= svc_valid_nx_s;
            svc_ch_r    <= svc_ch_nx_s;
            ptr_r       <= ptr_nx_s;
        end
    end

    assign HRQ       = hrq_r;
    assign DACK      = dack_r;
    assign svc_valid = svc_valid_r;
    assign svc_ch    = svc_ch_r;

endmodule

// File: tb/tb_dma_prio_arbiter.sv
// Directed bench for dma_prio_arbiter (4 channels, DREQ active high, DACK active low).
module tb_dma_prio_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       HLDA;
    logic       HRQ;
    logic [3:0] DACK;
    logic [3:0] cfg_mask;
    logic       cfg_rot_prio;
    logic       sw_req_set;
    logic       sw_req_clr;
    logic [1:0] sw_req_ch;
    logic       svc_valid;
    logic [1:0] svc_ch;
    logic       svc_done;
    logic       svc_tc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    dma_prio_arbiter #(
        .NUM_CH           (4),
        .DREQ_ACTIVE_HIGH (1),
        .DACK_ACTIVE_HIGH (0),
        .SYNC_STAGES      (2)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DREQ         (DREQ),
        .HLDA         (HLDA),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .cfg_mask     (cfg_mask),
        .cfg_rot_prio (cfg_rot_prio),
`ifdef DMA_SW_REQ_EN
        .sw_req_set   (sw_req_set),
        .sw_req_clr   (sw_req_clr),
        .sw_req_ch    (sw_req_ch),
`endif
        .svc_valid    (svc_valid),
        .svc_ch       (svc_ch),
        .svc_done     (svc_done),
        .svc_tc       (svc_tc)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET_N      = 1'b0;
        DREQ         = 4'b0000;
        HLDA         = 1'b0;
        cfg_mask     = 4'b0000;
        cfg_rot_prio = 1'b0;
        sw_req_set   = 1'b0;
        sw_req_clr   = 1'b0;
        sw_req_ch    = 2'd0;
        svc_done     = 1'b0;
        svc_tc       = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick(1);
    endtask

    task automatic wait_hrq(input string tag);
        int cnt = 0;
        while (HRQ !== 1'b1 && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check(tag, {31'd0, HRQ}, 32'd1);
    endtask

    // Pulse svc_done, then drop HLDA so the sequencer returns to idle
    task automatic finish_svc();
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        HLDA     = 1'b0;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] one;

        // Reset state
        do_reset();
        check("rst_hrq", {31'd0, HRQ}, 32'd0);
        check("rst_dack", {28'd0, DACK}, 32'hF);
        check("rst_valid", {31'd0, svc_valid}, 32'd0);
        check("rst_ch", {30'd0, svc_ch}, 32'd0);

        // 1. Fixed priority, latency and re-request
        DREQ = 4'b0110;
        tick(2);
        check("t1_lat_early", {31'd0, HRQ}, 32'd0);
        tick(1);
        check("t1_lat_hrq", {31'd0, HRQ}, 32'd1);
        tick(2);
        HLDA = 1'b1;
        check("t1_no_dack_yet", {28'd0, DACK}, 32'hF);
        tick(1);
        check("t1_dack", {28'd0, DACK}, 32'hD);
        check("t1_ch", {30'd0, svc_ch}, 32'd1);
        check("t1_valid", {31'd0, svc_valid}, 32'd1);
        DREQ     = 4'b0100;
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        check("t1_done_hrq", {31'd0, HRQ}, 32'd0);
        check("t1_done_dack", {28'd0, DACK}, 32'hF);
        check("t1_done_valid", {31'd0, svc_valid}, 32'd0);
        tick(3);
        check("t1_no_hrq_hlda_hi", {31'd0, HRQ}, 32'd0);
        HLDA = 1'b0;
        wait_hrq("t1_rehrq");
        HLDA = 1'b1;
        tick(1);
        check("t1_ch2", {30'd0, svc_ch}, 32'd2);
        check("t1_dack2", {28'd0, DACK}, 32'hB);
        DREQ = 4'b0000;
        finish_svc();

        // 2. Rotating priority with all channels requesting
        do_reset();
        cfg_rot_prio = 1'b1;
        DREQ         = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_hrq("t2_hrq");
            HLDA = 1'b1;
            tick(1);
            one = 4'b0001 << order[k];
            check("t2_rot_ch", {30'd0, svc_ch}, order[k]);
            check("t2_rot_dack", {28'd0, DACK}, {28'd0, ~one});
            finish_svc();
        end
        DREQ = 4'b0000;

        // 3. Mask blocks request; masking mid-grant does not revoke
        do_reset();
        cfg_mask = 4'b0001;
        DREQ     = 4'b0001;
        tick(6);
        check("t3_masked_hrq", {31'd0, HRQ}, 32'd0);
        cfg_mask = 4'b0000;
        wait_hrq("t3_unmask_hrq");
        HLDA = 1'b1;
        tick(1);
        check("t3_dack0", {28'd0, DACK}, 32'hE);
        cfg_mask = 4'b0001;
        DREQ     = 4'b0000;
        tick(3);
        check("t3_keep_dack", {28'd0, DACK}, 32'hE);
        check("t3_keep_valid", {31'd0, svc_valid}, 32'd1);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        check("t3_done_dack", {28'd0, DACK}, 32'hF);
        HLDA = 1'b0;
        tick(2);

        // 4. Request withdrawn before HLDA; stray svc_done ignored
        do_reset();
        DREQ = 4'b1000;
        tick(1);
        DREQ = 4'b0000;
        tick(2);
        check("t4_hrq", {31'd0, HRQ}, 32'd1);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        tick(2);
        check("t4_hrq_held", {31'd0, HRQ}, 32'd1);
        HLDA = 1'b1;
        tick(1);
        check("t4_no_dack", {28'd0, DACK}, 32'hF);
        check("t4_rel_hrq", {31'd0, HRQ}, 32'd0);
        check("t4_no_valid", {31'd0, svc_valid}, 32'd0);
        HLDA = 1'b0;
        tick(3);
        check("t4_idle_hrq", {31'd0, HRQ}, 32'd0);

        // 5. Abort by HLDA drop, then asynchronous reset during grant
        do_reset();
        DREQ = 4'b0100;
        wait_hrq("t5_hrq");
        HLDA = 1'b1;
        tick(1);
        check("t5_dack2", {28'd0, DACK}, 32'hB);
        HLDA = 1'b0;
        tick(1);
        check("t5_abort_dack", {28'd0, DACK}, 32'hF);
        check("t5_abort_valid", {31'd0, svc_valid}, 32'd0);
        check("t5_abort_hrq", {31'd0, HRQ}, 32'd0);
        wait_hrq("t5_rehrq");
        HLDA = 1'b1;
        tick(1);
        check("t5_regrant", {28'd0, DACK}, 32'hB);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t5_rst_hrq", {31'd0, HRQ}, 32'd0);
        check("t5_rst_dack", {28'd0, DACK}, 32'hF);
        check("t5_rst_valid", {31'd0, svc_valid}, 32'd0);
        check("t5_rst_ch", {30'd0, svc_ch}, 32'd0);

`ifdef DMA_SW_REQ_EN
        // 6. Software requests
        do_reset();
        sw_req_ch  = 2'd2;
        sw_req_set = 1'b1;
        tick(1);
        sw_req_set = 1'b0;
        wait_hrq("t6_sw_hrq");
        HLDA = 1'b1;
        tick(1);
        check("t6_sw_ch", {30'd0, svc_ch}, 32'd2);
        check("t6_sw_dack", {28'd0, DACK}, 32'hB);
        svc_done = 1'b1;
        svc_tc   = 1'b1;
        tick(1);
        svc_done = 1'b0;
        svc_tc   = 1'b0;
        HLDA     = 1'b0;
        tick(4);
        check("t6_tc_clear", {31'd0, HRQ}, 32'd0);
        sw_req_set = 1'b1;
        sw_req_clr = 1'b1;
        tick(1);
        sw_req_set = 1'b0;
        sw_req_clr = 1'b0;
        tick(3);
        check("t6_clr_wins", {31'd0, HRQ}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
